// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b, LSB first, one full-subtractor cell with a registered borrow.
// Optional signed-overflow output enabled by defining SUB_OVERFLOW_EN.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
`ifdef SUB_OVERFLOW_EN
    output logic             overflow_o,
`endif
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] diff_o,
    output logic             borrow_o
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, sr_q, sr_d, diff_q, diff_d, sr_nx;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d, borrow_q, borrow_d;
    logic             accept, shifting, last, d_bit, br_nx;

    assign shifting = state_q == SHIFT;
    assign accept   = start_i && !shifting;
    assign last     = shifting && cnt_q == CW'(WIDTH - 1);
    assign d_bit    = sa_q[0] ^ sb_q[0] ^ br_q;
    assign br_nx    = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
    assign sr_nx    = (sr_q >> 1) | {d_bit, {(WIDTH-1){1'b0}}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = accept ? SHIFT : last ? DONE : (state_q == DONE) ? IDLE : state_q;
    end

    always_comb begin
        busy_o = state_q == SHIFT;
        done_o = state_q == DONE;
    end

    always_comb begin
        sa_d     = accept ? a_i : shifting ? sa_q >> 1 : sa_q;
        sb_d     = accept ? b_i : shifting ? sb_q >> 1 : sb_q;
        sr_d     = shifting ? sr_nx : sr_q;
        cnt_d    = accept ? '0 : shifting ? cnt_q + CW'(1) : cnt_q;
        br_d     = accept ? 1'b0 : shifting ? br_nx : br_q;
        diff_d   = last ? sr_nx : diff_q;
        borrow_d = last ? br_nx : borrow_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa_q     <= '0;
            sb_q     <= '0;
            sr_q     <= '0;
            cnt_q    <= '0;
            br_q     <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            sr_q     <= sr_d;
            cnt_q    <= cnt_d;
            br_q     <= br_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

    assign diff_o   = diff_q;
    assign borrow_o = borrow_q;

`ifdef SUB_OVERFLOW_EN
    // Operand MSBs are shifted out early, so keep the signs for the final overflow test.
    logic am_q, am_d, bm_q, bm_d, ov_q, ov_d;

    always_comb begin
        am_d = accept ? a_i[WIDTH-1] : am_q;
        bm_d = accept ? b_i[WIDTH-1] : bm_q;
        ov_d = last ? (am_q != bm_q) && (d_bit != am_q) : ov_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            am_q <= 1'b0;
            bm_q <= 1'b0;
            ov_q <= 1'b0;
        end else begin
            am_q <= am_d;
            bm_q <= bm_d;
            ov_q <= ov_d;
        end
    end

    assign overflow_o = ov_q;
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and random checks of serial_subtractor (WIDTH=8).
module tb_serial_subtractor;
    logic       clk = 1'b0;
    logic       rst_n, start_i, busy_o, done_o, borrow_o;
    logic [7:0] a_i, b_i, diff_o;
`ifdef SUB_OVERFLOW_EN
    logic       overflow_o;
`endif
    int checks = 0;
    int passes = 0;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start_i(start_i),
        .a_i(a_i),
        .b_i(b_i),
`ifdef SUB_OVERFLOW_EN
        .overflow_o(overflow_o),
`endif
        .busy_o(busy_o),
        .done_o(done_o),
        .diff_o(diff_o),
        .borrow_o(borrow_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // One operation with a single-cycle start; operands are scrambled right after accept.
    task automatic run(input logic [7:0] a, input logic [7:0] b, input logic [7:0] ed,
                       input logic eb, input logic eo, input string tag);
        logic [7:0] prev;
        int n, nb, held;
        @(negedge clk);
        a_i = a; b_i = b; start_i = 1'b1; prev = diff_o;
        @(negedge clk);
        start_i = 1'b0; a_i = 8'($urandom); b_i = 8'($urandom);
        n = 0; nb = 0; held = 1;
        while (done_o !== 1'b1 && n < 40) begin
            nb += int'(busy_o);
            if (diff_o !== prev) held = 0;
            n++;
            @(negedge clk);
        end
        chk({tag, " latency"}, n, 8);
        chk({tag, " busy_cycles"}, nb, 8);
        chk({tag, " held"}, held, 1);
        chk({tag, " diff"}, diff_o, ed);
        chk({tag, " borrow"}, borrow_o, eb);
`ifdef SUB_OVERFLOW_EN
        chk({tag, " overflow"}, overflow_o, eo);
`else
        if (eo === 1'bx) $display("note: unexpected X overflow expectation in %s", tag);
`endif
    endtask

    initial begin
        logic [7:0] ra, rb, rd;
        int dc, dok, bok;
        rst_n = 1'b0; start_i = 1'b0; a_i = '0; b_i = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst busy", busy_o, 0);
        chk("rst done", done_o, 0);
        chk("rst diff", diff_o, 0);
        chk("rst borrow", borrow_o, 0);
`ifdef SUB_OVERFLOW_EN
        chk("rst overflow", overflow_o, 0);
`endif

        run(8'd100, 8'd37, 8'd63, 1'b0, 1'b0, "100-37");
        run(8'd5, 8'd10, 8'd251, 1'b1, 1'b0, "5-10");
        run(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, "0-0");
        run(8'd255, 8'd255, 8'd0, 1'b0, 1'b0, "255-255");
        run(8'd0, 8'd1, 8'd255, 1'b1, 1'b0, "0-1");
        run(8'd128, 8'd1, 8'd127, 1'b0, 1'b1, "128-1");
        run(8'd127, 8'd255, 8'd128, 1'b1, 1'b1, "127-255");
        run(8'd50, 8'd20, 8'd30, 1'b0, 1'b0, "50-20");

        // start, a and b toggled randomly while shifting must be ignored
        @(negedge clk);
        a_i = 8'd77; b_i = 8'd33; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        for (int i = 0; i < 7; i++) begin
            start_i = 1'($urandom); a_i = 8'($urandom); b_i = 8'($urandom);
            @(negedge clk);
        end
        start_i = 1'b0;
        dc = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            dc += int'(done_o);
        end
        chk("toggle done_count", dc, 1);
        chk("toggle diff", diff_o, 44);
        chk("toggle borrow", borrow_o, 0);

        // start held high: back-to-back operations, done every 9 cycles
        @(negedge clk);
        a_i = 8'd20; b_i = 8'd7; start_i = 1'b1;
        dok = 0; bok = 0;
        for (int k = 0; k < 27; k++) begin
            @(negedge clk);
            dok += int'(done_o === (k % 9 == 8));
            bok += int'(busy_o === (k % 9 != 8));
        end
        start_i = 1'b0;
        chk("held done_pattern", dok, 27);
        chk("held busy_pattern", bok, 27);
        chk("held diff", diff_o, 13);

        run(8'd200, 8'd50, 8'd150, 1'b0, 1'b0, "200-50");
        run(8'd1, 8'd2, 8'd255, 1'b1, 1'b0, "1-2");

        // asynchronous reset in the middle of a=9,b=3
        @(negedge clk);
        a_i = 8'd9; b_i = 8'd3; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort busy", busy_o, 0);
        chk("abort done", done_o, 0);
        chk("abort diff", diff_o, 0);
        chk("abort borrow", borrow_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dc = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            dc += int'(done_o) + int'(busy_o);
        end
        chk("abort no_done", dc, 0);
        run(8'd9, 8'd3, 8'd6, 1'b0, 1'b0, "9-3");

        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rd = ra - rb;
            run(ra, rb, rd, ra < rb, (ra[7] != rb[7]) && (rd[7] != ra[7]), "rand");
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial two's-complement subtractor computing diff = a - b, LSB first, one bit per clock.
- Uses a single full-subtractor cell with a registered borrow. It is the subtraction counterpart of the ripple full-adder chain.
- Sits beside the 8-bit adder datapath as a low-area ALU resource, driven by a start/busy/done handshake.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when state is IDLE or DONE
- a  input  WIDTH  minuend; captured on accepted start
- b  input  WIDTH  subtrahend; captured on accepted start
- busy  output  1  high while an operation is in progress (state SHIFT)
- done  output  1  one-cycle pulse when diff/borrow are updated
- diff  output  WIDTH  result a - b mod 2^WIDTH; held until the next completion
- borrow  output  1  unsigned borrow-out (1 when a < b unsigned); held with diff

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state IDLE, busy 0, done 0, diff 0, borrow 0, internal shift registers 0, bit counter 0, borrow flop 0, overflow 0 (when enabled).
- States:
  - IDLE: idle.
  - SHIFT: processing bits.
  - DONE: single cycle; done=1.
- Transitions:
  - IDLE --start--> SHIFT.
  - SHIFT --count==WIDTH-1--> DONE.
  - DONE --start--> SHIFT (back-to-back accepted).
  - DONE --no start--> IDLE.
- Accept edge (start=1 in IDLE/DONE):
  - load sa<=a, sb<=b.
  - clear borrow flop br<=0 and counter<=0.
  - busy rises after this edge.
- Each SHIFT edge:
  - d = sa[0]^sb[0]^br.
  - br <= (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&br).
  - Result shift register sr <= {d, sr[WIDTH-1:1]}.
  - sa, sb shift right; counter increments.
- Completion (the SHIFT edge with counter==WIDTH-1):
  - diff <= {d, sr[WIDTH-1:1]}.
  - borrow <= next br value.
  - state -> DONE.
- Latency: start accepted at edge N gives processing edges N+1..N+WIDTH. done is high for exactly the cycle following edge N+WIDTH; diff/borrow are valid from that same edge.
- Throughput: one result per WIDTH+1 cycles when start is held high continuously.
- busy: 1 only in SHIFT; 0 in IDLE and DONE.
- start while in SHIFT: ignored; no effect on operands, counter or outputs.
- Operand changes after the accept edge: no effect (operands are captured).
- diff/borrow: change only at completion edges. They hold their value through IDLE and through the following operation until it completes.
- Reset asserted mid-operation: immediate abort to the reset values above. No done pulse; the partial result is discarded.
- Arithmetic: diff equals (a + ~b + 1) mod 2^WIDTH for all inputs. borrow = (a < b) unsigned.

Optional Feature:
- Macro: SUB_OVERFLOW_EN.
- Defined:
  - Adds output port overflow (1 bit), reset 0.
  - Updated with diff at completion: overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]). This is signed overflow of a - b, computed from the captured operand MSBs.
  - Held until the next completion.
- Not defined: port and logic absent; all other behaviour identical.

Test Plan:
- Basic subtraction: WIDTH=8, a=100, b=37, start for 1 cycle -> done pulses 9 cycles after the accept edge (the cycle after edge N+8); diff=63, borrow=0, busy high for exactly 8 cycles.
- Wrap-around: a=5, b=10 -> diff=251, borrow=1. Edge cases: a=0,b=0 -> diff=0, borrow=0; a=255,b=255 -> diff=0, borrow=0; a=0,b=1 -> diff=255, borrow=1.
- Handshake: pulse start, then toggle start, a and b randomly during SHIFT -> result equals the operands captured at accept; exactly one done pulse. Hold start high for 3 operations -> done every 9 cycles; busy low only in the DONE cycles.
- Hold behaviour: after a=200,b=50 completes (diff=150), start a=1,b=2 -> diff stays 150 until the second done, then becomes 255 with borrow=1.
- Reset mid-operation: assert rst_n=0 at the 4th SHIFT cycle of a=9,b=3 -> busy, done, diff, borrow all 0 asynchronously. No done pulse after release; the next operation a=9,b=3 yields diff=6.
- SUB_OVERFLOW_EN: a=128,b=1 -> diff=127, borrow=0, overflow=1; a=127,b=255 -> diff=128, borrow=1, overflow=1; a=50,b=20 -> overflow=0. Randomised 1000 pairs checked against a reference model of a-b, with and without the macro.
